adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one N-bit adder (adderNbit instance, unsigned add with carry-out) among 4 requesters.
- Round-robin arbitration; one accepted operation per cycle; result registered with valid/ready backpressure and tagged with requester ID.
- Sits between the requesting engines and the single adder instance in the arithmetic datapath.

Parameters:
- N, 8, operand and sum width in bits (N >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  4  bit i: requester i has an operation pending.
- req_a  input  4*N  packed operand A; requester i occupies bits [i*N +: N].
- req_b  input  4*N  packed operand B; same packing as req_a.
- req_ready  output  4  one-hot grant; bit i high means requester i's operands are accepted this cycle.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  downstream accepts the result this cycle.
- res_sum  output  N  registered A+B, low N bits.
- res_cout  output  1  registered carry-out of A+B.
- res_id  output  2  index of the requester that produced the result.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset, sampled at a clk edge with rst=1:
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, round-robin pointer ptr=0.
  - req_ready is forced to 0 while rst=1.
- Output slot:
  - slot_free = !res_valid || res_ready (combinational).
  - No grant is issued unless slot_free=1.
- Grant, combinational from req_valid, ptr and slot_free:
  - Scan requesters ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first one with req_valid=1 gets req_ready=1.
  - req_ready is at most one-hot; all zero if no request or !slot_free.
- Handshake:
  - A transfer occurs on requester i when req_valid[i] && req_ready[i] at the clk edge.
  - Requesters hold req_valid and operands stable until granted; the block does not depend on this for correctness.
  - req_ready never depends on req_a or req_b.
- On a transfer at edge t:
  - res_sum/res_cout = {carry, sum} of req_a[i] + req_b[i], computed at full N+1 width. No signed interpretation; overflow appears only as res_cout.
  - res_id=i and res_valid=1 are visible after edge t, so latency is 1 cycle from grant to res_valid.
  - ptr <= (i+1) mod 4.
- With no transfer:
  - ptr is unchanged.
  - If res_valid && res_ready, then res_valid <= 0; res_sum, res_cout and res_id hold their last values.
  - If res_valid && !res_ready, all result outputs hold stable. A stalled result must never change.
- Simultaneous consume and grant in the same cycle: the new result replaces the old one, res_valid stays 1, giving full throughput of 1 op/cycle.
- Fairness: with all 4 requesters continuously valid and res_ready=1, grants rotate 0,1,2,3,0,... A continuously valid requester waits at most 3 grants.
- Reset mid-operation: a pending result is discarded (res_valid=0). Requests outstanding at reset are not granted until after rst falls. ptr restarts at 0.
- The adder function uses the same sum/carry semantics as adderNbit. Implementation may instantiate adderNbit on the muxed operands or compute inline.

Test Plan:
- Reset and idle (N=8): rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, res_valid=0, res_sum=0, res_cout=0, res_id=0. rst=0, req_valid=0 -> no grants, res_valid stays 0.
- Single request with carry: req_valid=4'b0100, A2=8'hFF, B2=8'h01, res_ready=1 -> req_ready=4'b0100 in that cycle. Next cycle res_valid=1, res_sum=8'h00, res_cout=1, res_id=2.
- Round-robin sweep: all four valid, operands Ai=10*i+5 and Bi=3, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3. res_sum sequence 8,18,28,38,... and res_cout=0 throughout.
- Backpressure: result pending with res_id=1 and res_sum=8'h80 (A=8'h55, B=8'h2B); hold res_ready=0 for 3 cycles with requesters valid -> req_ready=0 throughout and outputs stable. Raise res_ready -> a grant is issued in that same cycle, and the next result appears the following cycle.
- Pointer skip: ptr=3 (last grant to 2), req_valid=4'b0011 -> grant to 0, then 1. Result 8'hAA+8'h55 gives res_sum=8'hFF, res_cout=0.
- Reset mid-stall: res_valid=1 with res_ready=0, then rst=1 for one cycle -> res_valid=0. After rst falls, the first grant goes to the lowest-index valid requester (ptr=0).

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: four requesters share one N-bit unsigned adder.
// A round-robin grant accepts at most one operation per cycle. The
// {carry, sum} result is registered with valid/ready backpressure and is
// tagged with the index of the requester that produced it.
module adder_share_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  input  logic [4*N-1:0] req_a,
  input  logic [4*N-1:0] req_b,
  output logic [3:0]     req_ready,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_sum,
  output logic           res_cout,
  output logic [1:0]     res_id
);

  logic [1:0]   ptr_q, ptr_d;
  logic         res_valid_q, res_valid_d;
  logic [N-1:0] res_sum_q, res_sum_d;
  logic         res_cout_q, res_cout_d;
  logic [1:0]   res_id_q, res_id_d;

  logic         slot_free;
  logic         gnt_any;
  logic [1:0]   gnt_idx;
  logic [3:0]   gnt_onehot;
  logic [N-1:0] a_sel, b_sel;
  logic [N:0]   add_full;

  // The result register can take a new value when it is empty, or when it
  // is being consumed in this same cycle.
  assign slot_free = !res_valid_q || res_ready;

  // Round-robin scan starting at ptr. The first valid requester wins.
  // Operands are never inspected, so the grant does not depend on them.
  always_comb begin
    logic [1:0] idx;
    gnt_any    = 1'b0;
    gnt_idx    = 2'd0;
    gnt_onehot = 4'b0000;
    idx        = 2'd0;
    if (slot_free && !rst) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!gnt_any && req_valid[idx]) begin
          gnt_any         = 1'b1;
          gnt_idx         = idx;
          gnt_onehot[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = gnt_onehot;

  // Select the granted requester's operands and feed them to the shared adder.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_idx == 2'(i)) begin
        a_sel = req_a[i*N +: N];
        b_sel = req_b[i*N +: N];
      end
    end
  end

  // Unsigned add at full N+1 width; the top bit is the carry-out.
  assign add_full = {1'b0, a_sel} + {1'b0, b_sel};

  // Next state of the result slot and the pointer. A grant in the same
  // cycle as a consume overwrites the slot, giving one result per cycle.
  // A stalled result is left untouched.
  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_id_d    = res_id_q;
    if (gnt_any) begin
      res_valid_d = 1'b1;
      res_sum_d   = add_full[N-1:0];
      res_cout_d  = add_full[N];
      res_id_d    = gnt_idx;
      ptr_d       = gnt_idx + 2'd1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Registered state with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;

endmodule
